fsm_step_sequencer: RTL and testbench

- Controller that sequences the team's x/y-driven state machine (state-decoded 3-bit output z) through a programmed list of input steps.
- Each step drives x/y for a set number of cycles, then compares the machine's z output against an expected code.
- Used for bring-up and self-test: software loads a step table, pulses start, and reads back pass or the first failing step index.
- Sits between the config bus and the controlled FSM; the sequencer owns that FSM's reset and its x/y inputs.

---
 rtl/fsm_pkg.sv | 48 ++++
 rtl/fsm_step_mem.sv | 26 ++
 rtl/fsm_step_sequencer.sv | 150 +++++++++++++++
 tb/tb_fsm_step_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the step sequencer and the x/y-driven FSM it controls:
// controlled-FSM state and z codes, step-entry field layout, sequencer states.
package fsm_pkg;

  localparam logic [2:0] ST_S7    = 3'd0;
  localparam logic [2:0] ST_S1    = 3'd1;
  localparam logic [2:0] ST_S5    = 3'd2;
  localparam logic [2:0] ST_S6    = 3'd3;
  localparam logic [2:0] ST_S9    = 3'd4;
  localparam logic [2:0] ST_S10   = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd7;

  localparam logic [2:0] Z_S1    = 3'd5;
  localparam logic [2:0] Z_S5    = 3'd1;
  localparam logic [2:0] Z_S6    = 3'd2;
  localparam logic [2:0] Z_S7    = 3'd0;
  localparam logic [2:0] Z_S9    = 3'd1;
  localparam logic [2:0] Z_S10   = 3'd0;
  localparam logic [2:0] Z_ERROR = 3'd7;

  // Entry is {x, y, exp_z[2:0], hold}; offsets are relative to the top of the hold field.
  localparam int ENT_EXP_OFS = 0;
  localparam int ENT_EXP_W   = 3;
  localparam int ENT_Y_OFS   = 3;
  localparam int ENT_X_OFS   = 4;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_RST_FSM,
    SEQ_SETTLE,
    SEQ_DRIVE,
    SEQ_CHECK,
    SEQ_FIN
  } seq_state_t;

  function automatic logic [2:0] fsm_z_of(input logic [2:0] s);
    case (s)
      ST_S1:   fsm_z_of = Z_S1;
      ST_S5:   fsm_z_of = Z_S5;
      ST_S6:   fsm_z_of = Z_S6;
      ST_S9:   fsm_z_of = Z_S9;
      ST_S10:  fsm_z_of = Z_S10;
      ST_S7:   fsm_z_of = Z_S7;
      default: fsm_z_of = Z_ERROR;
    endcase
  endfunction

endpackage

// File: rtl/fsm_step_mem.sv
// Step table: DEPTH x W register file, one write port, combinational read port.
// Contents are deliberately not reset; software always loads the table before a run.
module fsm_step_mem
  import fsm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fsm_step_sequencer.sv
// Runs a programmed list of x/y steps into the controlled FSM and checks its z output per step.
// Run takes 2 + sum(hold+2) + 1 cycles from start to done; start/cfg_we are ignored while busy.
module fsm_step_sequencer
  import fsm_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int HOLD_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [5+HOLD_W-1:0] cfg_data,
  input  logic [AW-1:0]       cfg_last,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [AW-1:0]       fail_idx,
  output logic                fsm_rst,
  output logic                fsm_x,
  output logic                fsm_y,
  input  logic [2:0]          fsm_z
);

  localparam int EW = 5 + HOLD_W;

  seq_state_t          state, state_nx;
  logic [AW-1:0]       idx, idx_nx;
  logic [AW-1:0]       last, last_nx;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nx;
  logic                pass_nx;
  logic [AW-1:0]       fail_idx_nx;

  logic [EW-1:0]        entry;
  logic                 ent_x, ent_y;
  logic [2:0]           ent_exp;
  logic [HOLD_W-1:0]    ent_hold;

  fsm_step_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (cfg_we && (state == SEQ_IDLE)),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx),
    .rdata (entry)
  );

  assign ent_hold = entry[HOLD_W-1:0];
  assign ent_exp  = entry[HOLD_W+ENT_EXP_OFS +: ENT_EXP_W];
  assign ent_y    = entry[HOLD_W+ENT_Y_OFS];
  assign ent_x    = entry[HOLD_W+ENT_X_OFS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEQ_IDLE;
      idx      <= '0;
      last     <= '0;
      hold_cnt <= '0;
      pass     <= 1'b0;
      fail_idx <= '0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      last     <= last_nx;
      hold_cnt <= hold_cnt_nx;
      pass     <= pass_nx;
      fail_idx <= fail_idx_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    last_nx     = last;
    hold_cnt_nx = hold_cnt;
    pass_nx     = pass;
    fail_idx_nx = fail_idx;
    busy        = 1'b1;
    done        = 1'b0;
    fsm_rst     = 1'b0;
    fsm_x       = 1'b0;
    fsm_y       = 1'b0;

    case (state)
      SEQ_IDLE: begin
        busy = 1'b0;
        if (start) begin
          last_nx  = (int'(cfg_last) > DEPTH - 1) ? AW'(DEPTH - 1) : cfg_last;
          idx_nx   = '0;
          state_nx = SEQ_RST_FSM;
        end
      end
      SEQ_RST_FSM: begin
        fsm_rst  = 1'b1;
        state_nx = SEQ_SETTLE;
      end
      SEQ_SETTLE: begin
        hold_cnt_nx = '0;
        state_nx    = SEQ_DRIVE;
      end
      SEQ_DRIVE: begin
        fsm_x = ent_x;
        fsm_y = ent_y;
        if (hold_cnt == ent_hold) state_nx = SEQ_CHECK;
        else                      hold_cnt_nx = hold_cnt + 1'b1;
      end
      SEQ_CHECK: begin
        fsm_x = ent_x;
        fsm_y = ent_y;
        // ERROR z fails the step even if the table expects 7.
        if ((fsm_z != ent_exp) || (fsm_z == Z_ERROR)) begin
          pass_nx     = 1'b0;
          fail_idx_nx = idx;
          state_nx    = SEQ_FIN;
        end else if (idx == last) begin
          pass_nx     = 1'b1;
          fail_idx_nx = '0;
          state_nx    = SEQ_FIN;
        end else begin
          idx_nx      = idx + 1'b1;
          hold_cnt_nx = '0;
          state_nx    = SEQ_DRIVE;
        end
      end
      SEQ_FIN: begin
        done     = 1'b1;
        state_nx = SEQ_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = SEQ_IDLE;
      end
    endcase

    // Abort discards the run's result but keeps the last reported failing index.
    if (abort && (state != SEQ_IDLE)) begin
      state_nx    = SEQ_IDLE;
      pass_nx     = 1'b0;
      fail_idx_nx = fail_idx;
    end
  end

endmodule

// File: tb/tb_fsm_step_sequencer.sv
// Bench for fsm_step_sequencer: models the controlled FSM and scoreboards each run's result/latency.
module tb_fsm_step_sequencer;
  import fsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [8:0] cfg_data;
  logic [3:0] cfg_last;
  logic       start;
  logic       abort;
  logic       busy, done, pass;
  logic [3:0] fail_idx;
  logic       fsm_rst, fsm_x, fsm_y;
  logic [2:0] fsm_z;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       pass;
    logic [3:0] fail_idx;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fsm_step_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_last (cfg_last),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_idx (fail_idx),
    .fsm_rst  (fsm_rst),
    .fsm_x    (fsm_x),
    .fsm_y    (fsm_y),
    .fsm_z    (fsm_z)
  );

  // Stand-in for the controlled FSM; shares rst and also resets on fsm_rst.
  function automatic logic [2:0] model_next(input logic [2:0] s, input logic x, input logic y);
    model_next = s;
    case (s)
      ST_S7:  case ({x, y}) 2'b01: model_next = ST_S10; 2'b11: model_next = ST_S1;
                            2'b10: model_next = ST_S5;  default: model_next = s; endcase
      ST_S10: case ({x, y}) 2'b01: model_next = ST_S1;  2'b11: model_next = ST_S9;
                            default: model_next = s; endcase
      ST_S1:  case ({x, y}) 2'b11: model_next = ST_S5;  2'b10: model_next = ST_S6;
                            default: model_next = s; endcase
      ST_S5:  if (x && y) model_next = ST_S6;
      ST_S6:  if (x && y) model_next = ST_S9;
      ST_S9:  if (x && !y) model_next = ST_ERROR;
      default: model_next = s;
    endcase
  endfunction

  logic [2:0] fs;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          fs <= ST_S7;
    else if (fsm_rst) fs <= ST_S7;
    else              fs <= model_next(fs, fsm_x, fsm_y);
  end
  assign fsm_z = fsm_z_of(fs);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ent(input logic x, input logic y, input logic [2:0] e, input logic [3:0] h);
    ent = {x, y, e, h};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [8:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Starts a run, optionally writes with start or injects start+cfg_we mid-run, then
  // pops the scoreboard when done appears. Cycle 1 is the cycle after the start-accept edge.
  task automatic run_seq(input logic [3:0] last, input logic e_pass, input logic [3:0] e_fail,
                         input int e_lat, input int e_xy, input int inj_cyc,
                         input logic wr_now, input logic [3:0] wr_addr, input logic [8:0] wr_data);
    exp_t e, g;
    int   cyc, xy;
    bit   seen;
    e.pass = e_pass; e.fail_idx = e_fail; e.lat = e_lat;
    sb.push_back(e);
    @(negedge clk);
    cfg_last = last; start = 1'b1;
    if (wr_now) begin cfg_we = 1'b1; cfg_addr = wr_addr; cfg_data = wr_data; end
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    cyc = 1; xy = 0; seen = 1'b0;
    chk("fsm_rst_pulse", fsm_rst, 1);
    while (cyc < 200 && !seen) begin
      if (fsm_x && fsm_y) xy++;
      if (inj_cyc != 0 && cyc == inj_cyc) begin
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = ent(1, 1, 3, 2); start = 1'b1;
      end else if (inj_cyc != 0 && cyc == inj_cyc + 1) begin
        cfg_we = 1'b0; start = 1'b0;
      end
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    cfg_we = 1'b0; start = 1'b0;
    if (!seen) begin
      chk("done_timeout", 0, 1);
      void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      g = sb.pop_front();
      chk("pass", pass, g.pass);
      chk("fail_idx", fail_idx, g.fail_idx);
      chk("latency", cyc, g.lat);
      if (e_xy >= 0) chk("xy_cycles", xy, e_xy);
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    bit done_seen;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_last = '0;
    start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_idx", fail_idx, 0);
    chk("rst_fsm_rst", fsm_rst, 0);
    chk("rst_fsm_xy", {fsm_x, fsm_y}, 0);
    rst = 1'b0;

    // Pass path: S7 -> S10 (z=0) -> S1 (z=5).
    wr(0, ent(0, 1, 0, 0));
    wr(1, ent(0, 1, 5, 0));
    run_seq(1, 1, 0, 7, -1, 0, 0, 0, '0);

    // Fail path on step 1.
    wr(1, ent(0, 1, 1, 0));
    run_seq(1, 0, 1, 7, -1, 0, 0, 0, '0);

    // Write in the same cycle as start lands first and fixes step 1.
    run_seq(1, 1, 0, 7, -1, 0, 1, 1, ent(0, 1, 5, 0));

    // Hold count: x=y=1 for 4 DRIVE cycles plus CHECK, reaching S9.
    wr(0, ent(1, 1, 1, 3));
    run_seq(0, 1, 0, 8, 5, 0, 0, 0, '0);

    // Abort during DRIVE of a 3-step hold=5 run.
    for (int i = 0; i < 3; i++) wr(4'(i), ent(0, 1, 5, 5));
    @(negedge clk);
    cfg_last = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_xy", {fsm_x, fsm_y}, 0);
    chk("abort_pass", pass, 0);
    chk("abort_fail_idx", fail_idx, 0);
    done_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", done_seen, 0);

    // Rerun from idx 0, then a run with start/cfg_we injected while busy, then readback.
    run_seq(2, 1, 0, 24, -1, 0, 0, 0, '0);
    run_seq(2, 1, 0, 24, -1, 6, 0, 0, '0);
    run_seq(2, 1, 0, 24, -1, 0, 0, 0, '0);

    // ERROR z fails even though the table expects 7.
    wr(0, ent(1, 1, 1, 3));
    wr(1, ent(1, 0, 7, 0));
    run_seq(1, 0, 1, 10, -1, 0, 0, 0, '0);

    // Full table, last index.
    for (int i = 0; i < 16; i++) wr(4'(i), ent(0, 0, 0, 0));
    run_seq(15, 1, 0, 35, -1, 0, 0, 0, '0);

    // Async reset mid-CHECK.
    wr(0, ent(0, 1, 0, 0));
    wr(1, ent(0, 1, 5, 0));
    @(negedge clk);
    cfg_last = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_y", fsm_y, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_xy", {fsm_x, fsm_y}, 0);
    chk("arst_pass", pass, 0);
    chk("arst_fsm_rst", fsm_rst, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table survives reset.
    run_seq(1, 1, 0, 7, -1, 0, 0, 0, '0);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
